// File: rtl/cmd_in_pkg.sv
// Shared definitions for the command-in fetch stage: header codes, field positions,
// command length rules and the fetch FSM state encoding.
package cmd_in_pkg;

    localparam logic [7:0] CODE_EMPTY         = 8'h00;
    localparam logic [7:0] CODE_EXEC_TASK     = 8'h01;
    localparam logic [7:0] CODE_SETUP_INST    = 8'h02;
    localparam logic [7:0] CODE_EXEC_PERIODIC = 8'h03;

    localparam int HDR_CODE_LSB  = 0;
    localparam int HDR_NARGS_LSB = 8;

    localparam logic [9:0] BASE_LEN_TASK  = 10'd3;
    localparam logic [9:0] BASE_LEN_OTHER = 10'd4;
    localparam logic [9:0] ARGS_STRIDE    = 10'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_WAIT,
        ST_HDR_CHK,
        ST_NXT_RD,
        ST_NXT_WAIT,
        ST_NXT_CHK,
        ST_COPT,
        ST_STREAM,
        ST_CLEAR,
        ST_HALT
    } state_t;

    function automatic logic code_legal(input logic [7:0] code);
        return (code == CODE_EXEC_TASK) || (code == CODE_SETUP_INST) ||
               (code == CODE_EXEC_PERIODIC);
    endfunction

    // Worst case 4 + 3*255 = 769 still fits in 10 bits.
    function automatic logic [9:0] cmd_len(input logic [1:0] cmd_type, input logic [7:0] nargs);
        return ((cmd_type == 2'd0) ? BASE_LEN_TASK : BASE_LEN_OTHER) + ARGS_STRIDE * {2'b00, nargs};
    endfunction

endpackage

// File: rtl/cmd_in_fetch_skid.sv
// Stream engine: issues 1-cycle-latency BRAM reads for one command and presents them
// as AXI-Stream beats through a 2-entry skid buffer, so backpressure never loses data.
module cmd_in_fetch_skid
    import cmd_in_pkg::*;
#(
    parameter int SB = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [SB-1:0] base_idx,
    input  logic [9:0]    len,
    output logic          rd_en,
    output logic [SB-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic [63:0]   tdata,
    output logic          tvalid,
    input  logic          tready,
    output logic          tlast,
    output logic          done
);

    logic [9:0]    issue_left;
    logic [SB-1:0] ptr;
    logic          pend;
    logic          pend_last;
    logic [1:0]    cnt;
    logic [63:0]   d0, d1;
    logic          l0, l1;
    logic          pop;

    logic [1:0]    n_cnt;
    logic [63:0]   n_d0, n_d1;
    logic          n_l0, n_l1;

    assign tvalid  = (cnt != 2'd0);
    assign tdata   = d0;
    assign tlast   = l0;
    assign pop     = tvalid && tready;
    assign done    = pop && l0;
    assign rd_addr = ptr;

    // Entries held plus the read in flight may never exceed the two skid slots.
    assign rd_en = (issue_left != 10'd0) &&
                   (({1'b0, cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        n_cnt = cnt;
        n_d0  = d0;
        n_d1  = d1;
        n_l0  = l0;
        n_l1  = l1;
        if (pop) begin
            n_d0  = d1;
            n_l0  = l1;
            n_cnt = cnt - 2'd1;
        end
        if (pend) begin
            if (n_cnt == 2'd0) begin
                n_d0 = rd_data;
                n_l0 = pend_last;
            end else begin
                n_d1 = rd_data;
                n_l1 = pend_last;
            end
            n_cnt = n_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_left <= '0;
            ptr        <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            cnt        <= '0;
            d0         <= '0;
            d1         <= '0;
            l0         <= 1'b0;
            l1         <= 1'b0;
        end else begin
            cnt       <= n_cnt;
            d0        <= n_d0;
            d1        <= n_d1;
            l0        <= n_l0;
            l1        <= n_l1;
            pend      <= rd_en;
            pend_last <= rd_en && (issue_left == 10'd1);
            if (start) begin
                ptr        <= base_idx;
                issue_left <= len;
            end else if (rd_en) begin
                ptr        <= ptr + 1'b1;
                issue_left <= issue_left - 10'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_in_fetch.sv
// Fetch stage for one cmd-in subqueue: poll header, measure, optional copy-opt pass,
// stream to the accelerator, free the slot. Copy-opt enabled by CMD_IN_FETCH_COPY_OPT_EN.
//
// state     | meaning
// IDLE      | issue header read at rd_idx
// HDR_WAIT  | BRAM read latency
// HDR_CHK   | decode header: empty -> repoll, illegal -> HALT, else latch length
// NXT_RD    | issue read of the following command's header
// NXT_WAIT  | BRAM read latency
// NXT_CHK   | decide whether the copy-opt pass runs
// COPT      | BRAM port owned by copy-opt until copt_finished
// STREAM    | words rd_idx..next_idx-1 streamed out
// CLEAR     | zero the code byte, advance rd_idx, pulse cmd_done
// HALT      | protocol error, wait for reset
module cmd_in_fetch
    import cmd_in_pkg::*;
#(
    parameter int                     SUBQUEUE_BITS = 6,
    parameter bit                     QUEUE_SEL     = 1'b0,
    parameter int                     ACC_ID_BITS   = 4,
    parameter logic [ACC_ID_BITS-1:0] ACC_ID        = '0
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic [SUBQUEUE_BITS-1:0] q_addr,
    output logic                     q_en,
    output logic [7:0]               q_we,
    output logic [63:0]              q_din,
    input  logic [63:0]              q_dout,
    output logic [63:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [ACC_ID_BITS-1:0]   m_axis_tdest,
    output logic                     cmd_done,
    output logic                     error,
    output logic                     copt_start,
    input  logic                     copt_finished,
    output logic [SUBQUEUE_BITS-1:0] copt_first_idx,
    output logic [SUBQUEUE_BITS-1:0] copt_first_next_idx,
    output logic [1:0]               copt_cmd_type,
    output logic                     copt_queue_select,
    input  logic [SUBQUEUE_BITS-1:0] copt_addr,
    input  logic                     copt_en,
    input  logic [7:0]               copt_we,
    input  logic [63:0]              copt_din
);

    localparam int SB     = SUBQUEUE_BITS;
    localparam int QWORDS = 1 << SB;

    state_t        state;
    logic [SB-1:0] rd_idx;
    logic [SB-1:0] next_idx;
    logic [9:0]    len;
    logic          fq_en;
    logic [SB-1:0] fq_addr;
    logic [7:0]    fq_we;
    logic          stream_start;
    logic          st_rd_en;
    logic [SB-1:0] st_rd_addr;
    logic          st_done;

    logic [7:0]    hdr_code;
    logic [7:0]    hdr_nargs;
    logic [1:0]    hdr_type;
    logic [9:0]    hdr_len;
    logic [SB-1:0] hdr_next;
    logic          hdr_ok;

    assign hdr_code  = q_dout[HDR_CODE_LSB +: 8];
    assign hdr_nargs = q_dout[HDR_NARGS_LSB +: 8];
    assign hdr_type  = hdr_code[1:0] - 2'd1;
    assign hdr_len   = cmd_len(hdr_type, hdr_nargs);
    assign hdr_next  = SB'(10'(rd_idx) + hdr_len);
    assign hdr_ok    = code_legal(hdr_code) && (int'(hdr_len) < QWORDS);

`ifdef CMD_IN_FETCH_COPY_OPT_EN
    logic          first_nargs_nz;
    logic [1:0]    cmd_type;
    logic          copt_start_r;
    logic [SB-1:0] copt_first_idx_r;
    logic [SB-1:0] copt_first_next_idx_r;
    logic [1:0]    copt_cmd_type_r;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            rd_idx       <= '0;
            next_idx     <= '0;
            len          <= '0;
            fq_en        <= 1'b0;
            fq_addr      <= '0;
            fq_we        <= '0;
            cmd_done     <= 1'b0;
            error        <= 1'b0;
            stream_start <= 1'b0;
`ifdef CMD_IN_FETCH_COPY_OPT_EN
            first_nargs_nz        <= 1'b0;
            cmd_type              <= '0;
            copt_start_r          <= 1'b0;
            copt_first_idx_r      <= '0;
            copt_first_next_idx_r <= '0;
            copt_cmd_type_r       <= '0;
`endif
        end else begin
            fq_en        <= 1'b0;
            fq_we        <= '0;
            cmd_done     <= 1'b0;
            stream_start <= 1'b0;
`ifdef CMD_IN_FETCH_COPY_OPT_EN
            copt_start_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    fq_en   <= 1'b1;
                    fq_addr <= rd_idx;
                    state   <= ST_HDR_WAIT;
                end
                ST_HDR_WAIT: state <= ST_HDR_CHK;
                ST_HDR_CHK: begin
                    if (hdr_code == CODE_EMPTY) begin
                        state <= ST_IDLE;
                    end else if (!hdr_ok) begin
                        error <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        len      <= hdr_len;
                        next_idx <= hdr_next;
`ifdef CMD_IN_FETCH_COPY_OPT_EN
                        cmd_type       <= hdr_type;
                        first_nargs_nz <= (hdr_nargs != 8'd0);
                        state          <= ST_NXT_RD;
`else
                        stream_start <= 1'b1;
                        state        <= ST_STREAM;
`endif
                    end
                end
`ifdef CMD_IN_FETCH_COPY_OPT_EN
                ST_NXT_RD: begin
                    fq_en   <= 1'b1;
                    fq_addr <= next_idx;
                    state   <= ST_NXT_WAIT;
                end
                ST_NXT_WAIT: state <= ST_NXT_CHK;
                ST_NXT_CHK: begin
                    if (hdr_code != CODE_EMPTY && first_nargs_nz && hdr_nargs != 8'd0) begin
                        copt_start_r          <= 1'b1;
                        copt_first_idx_r      <= rd_idx;
                        copt_first_next_idx_r <= next_idx;
                        copt_cmd_type_r       <= cmd_type;
                        state                 <= ST_COPT;
                    end else begin
                        stream_start <= 1'b1;
                        state        <= ST_STREAM;
                    end
                end
                ST_COPT: begin
                    if (copt_finished) begin
                        stream_start <= 1'b1;
                        state        <= ST_STREAM;
                    end
                end
`endif
                ST_STREAM: begin
                    if (st_done) begin
                        fq_en    <= 1'b1;
                        fq_we    <= 8'h01;
                        fq_addr  <= rd_idx;
                        cmd_done <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    rd_idx <= next_idx;
                    state  <= ST_IDLE;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

    cmd_in_fetch_skid #(.SB(SB)) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .start    (stream_start),
        .base_idx (rd_idx),
        .len      (len),
        .rd_en    (st_rd_en),
        .rd_addr  (st_rd_addr),
        .rd_data  (q_dout),
        .tdata    (m_axis_tdata),
        .tvalid   (m_axis_tvalid),
        .tready   (m_axis_tready),
        .tlast    (m_axis_tlast),
        .done     (st_done)
    );

    assign m_axis_tdest      = ACC_ID;
    assign copt_queue_select = QUEUE_SEL;

`ifdef CMD_IN_FETCH_COPY_OPT_EN
    logic in_copt;
    assign in_copt             = (state == ST_COPT);
    assign q_en                = in_copt ? copt_en : (fq_en | st_rd_en);
    assign q_addr              = in_copt ? copt_addr : (st_rd_en ? st_rd_addr : fq_addr);
    assign q_we                = in_copt ? copt_we : fq_we;
    assign q_din               = in_copt ? copt_din : 64'd0;
    assign copt_start          = copt_start_r;
    assign copt_first_idx      = copt_first_idx_r;
    assign copt_first_next_idx = copt_first_next_idx_r;
    assign copt_cmd_type       = copt_cmd_type_r;
`else
    logic unused_copt;
    assign unused_copt         = ^{copt_finished, copt_addr, copt_en, copt_we, copt_din};
    assign q_en                = fq_en | st_rd_en;
    assign q_addr              = st_rd_en ? st_rd_addr : fq_addr;
    assign q_we                = fq_we;
    assign q_din               = 64'd0;
    assign copt_start          = 1'b0;
    assign copt_first_idx      = '0;
    assign copt_first_next_idx = '0;
    assign copt_cmd_type       = '0;
`endif

endmodule
